// File: rtl/barrel_pkg.sv
// barrel_pkg: shared types and default geometry for the barrel read path.
package barrel_pkg;

    localparam int COORD_W    = 12;
    localparam int DEF_WIDTH  = 1080;
    localparam int DEF_HEIGHT = 960;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FILL,
        STREAM,
        STALL,
        GAP,
        DONE
    } state_e;

endpackage

// File: rtl/barrel_raster_counter.sv
// barrel_raster_counter: raster-order x/y counter with wrap and end-of-line/frame flags.
module barrel_raster_counter #(
    parameter int WIDTH   = 1080,
    parameter int HEIGHT  = 960,
    parameter int COORD_W = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last_x,
    output logic               last_frame,
    output logic               nxt_first,
    output logic               nxt_last_x
);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(HEIGHT - 1);

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

    assign last_x     = x_q == X_MAX;
    assign last_frame = last_x && y_q == Y_MAX;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            x_d = last_x ? '0 : x_q + COORD_W'(1);
            y_d = last_x ? (last_frame ? '0 : y_q + COORD_W'(1)) : y_q;
        end
    end

    // Flags for the coordinate that will be presented next cycle.
    assign nxt_first  = x_d == '0 && y_d == '0;
    assign nxt_last_x = x_d == X_MAX;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/barrel_read_sequencer.sv
// barrel_read_sequencer: issues raster-order (x, y) reads with valid/SOF/EOL toward the barrel memory path.
// Define BARREL_SEQ_LINE_GAP_EN to insert LINE_GAP idle cycles after every line but the last.
module barrel_read_sequencer
    import barrel_pkg::*;
#(
    parameter int COORD_W  = barrel_pkg::COORD_W,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int LINE_GAP = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               frame_start,
    input  logic               mem_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sof,
    output logic               out_eol,
    output logic               busy,
    output logic               frame_done,
    output logic               underrun
);
    if (WIDTH < 1 || HEIGHT < 1 || LINE_GAP < 1 ||
        WIDTH > 2 ** COORD_W || HEIGHT > 2 ** COORD_W) begin : g_bad_params
        $error("barrel_read_sequencer: illegal WIDTH/HEIGHT/LINE_GAP/COORD_W");
    end

    state_e state_q, state_d;
    logic   valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
    logic   busy_q, busy_d, done_q, done_d, underrun_q, underrun_d;
    logic   start, beat, last_x, last_frame, nxt_first, nxt_last_x;
`ifdef BARREL_SEQ_LINE_GAP_EN
    localparam int GAP_W = $clog2(LINE_GAP + 1);
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    assign start = enable && frame_start && state_q == IDLE;
    assign beat  = valid_q && out_ready;

    barrel_raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .COORD_W(COORD_W)
    ) u_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (start),
        .advance   (beat),
        .x         (out_x),
        .y         (out_y),
        .last_x    (last_x),
        .last_frame(last_frame),
        .nxt_first (nxt_first),
        .nxt_last_x(nxt_last_x)
    );

    always_comb begin
        state_d = state_q;
`ifdef BARREL_SEQ_LINE_GAP_EN
        gap_d = gap_q;
`endif
        case (state_q)
            IDLE:      if (start) state_d = WAIT_FILL;
            WAIT_FILL: if (mem_ready) state_d = STREAM;
            STREAM: begin
                if (beat) begin
                    if (last_frame) state_d = DONE;
`ifdef BARREL_SEQ_LINE_GAP_EN
                    else if (last_x) begin
                        state_d = GAP;
                        gap_d   = GAP_W'(LINE_GAP - 1);
                    end
`endif
                    else if (!mem_ready) state_d = STALL;
                end
            end
            STALL:     if (mem_ready) state_d = STREAM;
`ifdef BARREL_SEQ_LINE_GAP_EN
            GAP: begin
                if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
                else state_d = mem_ready ? STREAM : STALL;
            end
`endif
            default:   state_d = IDLE;
        endcase
        if (!enable) state_d = IDLE;
        // Outputs are registered from the next state so they line up with it.
        valid_d    = state_d == STREAM;
        sof_d      = valid_d && nxt_first;
        eol_d      = valid_d && (beat ? nxt_last_x : last_x);
        busy_d     = state_d != IDLE;
        done_d     = state_d == DONE;
        underrun_d = !start && (underrun_q || (state_d == STALL && state_q != STALL));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef BARREL_SEQ_LINE_GAP_EN
            gap_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
`ifdef BARREL_SEQ_LINE_GAP_EN
            gap_q      <= gap_d;
`endif
        end
    end

    assign out_valid  = valid_q;
    assign out_sof    = sof_q;
    assign out_eol    = eol_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_barrel_read_sequencer.sv
// tb_barrel_read_sequencer: directed checks of raster order, backpressure, stall, gap, enable and reset.
module tb_barrel_read_sequencer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 12;
    localparam int LG = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          frame_start = 1'b0;
    logic          mem_ready = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_x, out_y;
    logic          out_valid, out_sof, out_eol, busy, frame_done, underrun;

    int n_cmp = 0;
    int n_err = 0;

    barrel_read_sequencer #(
        .COORD_W (CW),
        .WIDTH   (W),
        .HEIGHT  (H),
        .LINE_GAP(LG)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .frame_start(frame_start),
        .mem_ready  (mem_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("start_busy", busy, 1);
        check("start_valid", out_valid, 0);
    endtask

    // Walks all W*H beats; hold_idx/drop_idx/poke_idx inject backpressure, fill loss or a stray frame_start.
    task automatic run_beats(input int hold_idx, input int drop_idx, input int poke_idx);
        for (int i = 0; i < W * H; i++) begin
            int ex = i % W;
            int ey = i / W;
            tick();
            frame_start = 1'b0;
            check("beat_valid", out_valid, 1);
            check("beat_x", out_x, ex);
            check("beat_y", out_y, ey);
            check("beat_sof", out_sof, i == 0);
            check("beat_eol", out_eol, ex == W - 1);
            if (i == poke_idx) frame_start = 1'b1;
            if (i == hold_idx) begin
                out_ready = 1'b0;
                repeat (3) begin
                    tick();
                    check("hold_valid", out_valid, 1);
                    check("hold_x", out_x, ex);
                    check("hold_y", out_y, ey);
                end
                out_ready = 1'b1;
            end
            if (i == drop_idx) begin
                mem_ready = 1'b0;
                tick();
                check("stall_valid", out_valid, 0);
                check("stall_underrun", underrun, 1);
                check("stall_x", out_x, ex + 1);
                tick();
                check("stall_hold_valid", out_valid, 0);
                check("stall_busy", busy, 1);
                mem_ready = 1'b1;
            end
`ifdef BARREL_SEQ_LINE_GAP_EN
            if (ex == W - 1 && ey < H - 1) begin
                repeat (LG) begin
                    tick();
                    check("gap_valid", out_valid, 0);
                end
            end
`endif
        end
        tick();
        check("done_pulse", frame_done, 1);
        check("done_valid", out_valid, 0);
        check("done_busy", busy, 1);
        tick();
        check("done_clear", frame_done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_x", out_x, 0);
        check("rst_y", out_y, 0);
        check("rst_sof", out_sof, 0);
        check("rst_eol", out_eol, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_underrun", underrun, 0);
        reset_n   = 1'b1;
        enable    = 1'b1;
        mem_ready = 1'b1;
        out_ready = 1'b1;
        tick();

        // Clean frame with a stray frame_start mid-frame.
        start_frame();
        run_beats(-1, -1, 6);
        check("clean_underrun", underrun, 0);

        // Backpressure on beat (2,1).
        start_frame();
        run_beats(6, -1, -1);

        // Fill not ready at frame start.
        mem_ready = 1'b0;
        start_frame();
        repeat (3) begin
            tick();
            check("fill_valid", out_valid, 0);
            check("fill_busy", busy, 1);
        end
        mem_ready = 1'b1;
        run_beats(-1, -1, -1);

        // Underrun after beat (1,0); sticky past frame end.
        start_frame();
        run_beats(-1, 1, -1);
        check("underrun_sticky", underrun, 1);

        // New frame clears underrun; then stall and disable mid-frame.
        start_frame();
        check("underrun_cleared", underrun, 0);
        tick();
        check("en_sof", out_sof, 1);
        mem_ready = 1'b0;
        tick();
        check("en_underrun", underrun, 1);
        enable = 1'b0;
        tick();
        check("dis_busy", busy, 0);
        check("dis_valid", out_valid, 0);
        check("dis_done", frame_done, 0);
        check("dis_underrun", underrun, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("dis_start_ignored", busy, 0);
        check("dis_done2", frame_done, 0);
        enable    = 1'b1;
        mem_ready = 1'b1;

        // Asynchronous reset mid-frame.
        start_frame();
        tick();
        mem_ready = 1'b0;
        tick();
        mem_ready = 1'b1;
        tick();
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_x", out_x, 1);
        check("pre_rst_underrun", underrun, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_x", out_x, 0);
        check("arst_busy", busy, 0);
        check("arst_underrun", underrun, 0);
        check("arst_done", frame_done, 0);
        tick();
        check("arst_held_done", frame_done, 0);
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
